// File: rtl/rat_pkg.sv
// Shared definitions for the interrupt controller: default widths/vectors and FSM states.
package rat_pkg;

   localparam int unsigned PC_W_DEF = 10;
   localparam logic [9:0]  VEC_BASE_DEF = 10'h3F8;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } state_e;

   // Channel-index width; a single channel still needs one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for one interrupt line with a rising-edge detector.
module irq_sync (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   output logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= irq;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;

endmodule

// File: rtl/rat_int_ctrl.sv
// Interrupt controller: synchronised sources, pending/mask registers, fixed
// lowest-index priority and a two-state accept/return handshake with the control unit.
module rat_int_ctrl
   import rat_pkg::*;
#(
   parameter int unsigned      N_IRQ     = 4,
   parameter int unsigned      PC_W      = PC_W_DEF,
   parameter logic [PC_W-1:0]  VEC_BASE  = PC_W'(VEC_BASE_DEF),
   parameter logic [N_IRQ-1:0] EDGE_MODE = {N_IRQ{1'b1}},
   parameter logic [N_IRQ-1:0] MASK_RST  = {N_IRQ{1'b1}},
   localparam int unsigned     ID_W      = id_width(N_IRQ)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_IRQ-1:0] IRQ,
   input  logic             MASK_WR,
   input  logic [N_IRQ-1:0] MASK_DIN,
   input  logic             SEI,
   input  logic             CLI,
   input  logic             INT_ACK,
   input  logic             RETIE,
   input  logic             C_FLG,
   input  logic             Z_FLG,
   output logic             INT_REQ,
   output logic [PC_W-1:0]  INT_VEC,
   output logic [ID_W-1:0]  INT_ID,
   output logic             SHAD_C,
   output logic             SHAD_Z,
   output logic             IE,
   output logic             IN_SERVICE,
   output logic [N_IRQ-1:0] PENDING
);

   logic [N_IRQ-1:0] sync_lvl;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] mask;
   logic [N_IRQ-1:0] req_vec;
   logic [N_IRQ-1:0] pending_n;
   logic [N_IRQ-1:0] clr;

   state_e           state;
   state_e           state_n;
   logic             ie_n;
   logic             accept;
   logic             retie_eff;
   logic [ID_W-1:0]  win_id;
   logic [PC_W-1:0]  win_vec;
   logic [ID_W-1:0]  int_id_n;
   logic [PC_W-1:0]  int_vec_n;
   logic             shad_c_n;
   logic             shad_z_n;

   for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
      irq_sync u_sync (
         .clk   (CLK),
         .rst   (RESET),
         .irq   (IRQ[g]),
         .level (sync_lvl[g]),
         .rise  (rise[g])
      );
   end

   assign req_vec    = PENDING & mask;
   assign IN_SERVICE = (state == SERVICE);
   assign INT_REQ    = IE & ~IN_SERVICE & (|req_vec);

   // Scan downwards so the lowest-index request is the last one assigned.
   always_comb begin
      win_id = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req_vec[i]) win_id = ID_W'(i);
      end
   end

   assign win_vec = VEC_BASE + PC_W'(win_id);

   // Next state, captured context and IE update.
   always_comb begin
      state_n   = state;
      ie_n      = IE;
      int_id_n  = INT_ID;
      int_vec_n = INT_VEC;
      shad_c_n  = SHAD_C;
      shad_z_n  = SHAD_Z;
      clr       = '0;
      accept    = 1'b0;
      retie_eff = 1'b0;
      case (state)
         IDLE: begin
            if (INT_ACK && INT_REQ) begin
               accept    = 1'b1;
               state_n   = SERVICE;
               int_id_n  = win_id;
               int_vec_n = win_vec;
               shad_c_n  = C_FLG;
               shad_z_n  = Z_FLG;
               clr       = EDGE_MODE & (N_IRQ'(1) << win_id);
            end else if (RETIE) begin
               retie_eff = 1'b1;
            end
         end
         SERVICE: begin
            if (RETIE) begin
               retie_eff = 1'b1;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (CLI)                    ie_n = 1'b0;
      else if (accept)            ie_n = 1'b0;
      else if (SEI || retie_eff)  ie_n = 1'b1;
   end

   // Edge channels latch (a new edge beats the accept clear); level channels track.
   always_comb begin
      pending_n = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (EDGE_MODE[i]) pending_n[i] = (PENDING[i] & ~clr[i]) | rise[i];
         else              pending_n[i] = sync_lvl[i];
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         IE      <= 1'b0;
         PENDING <= '0;
         mask    <= MASK_RST;
         INT_ID  <= '0;
         INT_VEC <= VEC_BASE;
         SHAD_C  <= 1'b0;
         SHAD_Z  <= 1'b0;
      end else begin
         IE      <= ie_n;
         PENDING <= pending_n;
         INT_ID  <= int_id_n;
         INT_VEC <= int_vec_n;
         SHAD_C  <= shad_c_n;
         SHAD_Z  <= shad_z_n;
         if (MASK_WR) mask <= MASK_DIN;
      end
   end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Scoreboard bench for rat_int_ctrl: a default instance plus one with channel 0 in level mode.
module tb_rat_int_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] irq = '0;
   logic       mask_wr = 1'b0;
   logic [3:0] mask_din = '0;
   logic       sei = 1'b0, cli = 1'b0, int_ack = 1'b0, retie = 1'b0;
   logic       c_flg = 1'b0, z_flg = 1'b0;
   logic       int_req, shad_c, shad_z, ie, in_service;
   logic [9:0] int_vec;
   logic [1:0] int_id;
   logic [3:0] pending;

   logic [3:0] l_irq = '0;
   logic       l_sei = 1'b0, l_ack = 1'b0, l_retie = 1'b0, l_zero = 1'b0;
   logic [3:0] l_mask_din = '0;
   logic       l_int_req, l_shad_c, l_shad_z, l_ie, l_in_service;
   logic [9:0] l_int_vec;
   logic [1:0] l_int_id;
   logic [3:0] l_pending;

   rat_int_ctrl dut (
      .CLK(clk), .RESET(rst), .IRQ(irq), .MASK_WR(mask_wr), .MASK_DIN(mask_din),
      .SEI(sei), .CLI(cli), .INT_ACK(int_ack), .RETIE(retie), .C_FLG(c_flg), .Z_FLG(z_flg),
      .INT_REQ(int_req), .INT_VEC(int_vec), .INT_ID(int_id), .SHAD_C(shad_c), .SHAD_Z(shad_z),
      .IE(ie), .IN_SERVICE(in_service), .PENDING(pending)
   );

   rat_int_ctrl #(.EDGE_MODE(4'b1110)) dut_lvl (
      .CLK(clk), .RESET(rst), .IRQ(l_irq), .MASK_WR(l_zero), .MASK_DIN(l_mask_din),
      .SEI(l_sei), .CLI(l_zero), .INT_ACK(l_ack), .RETIE(l_retie), .C_FLG(l_zero), .Z_FLG(l_zero),
      .INT_REQ(l_int_req), .INT_VEC(l_int_vec), .INT_ID(l_int_id), .SHAD_C(l_shad_c), .SHAD_Z(l_shad_z),
      .IE(l_ie), .IN_SERVICE(l_in_service), .PENDING(l_pending)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         inst;
      logic       rq;
      logic [3:0] pd;
      logic       e;
      logic       sv;
      bit         chk_acc;
      logic [1:0] id;
      logic [9:0] vec;
      logic       sc;
      logic       sz;
   } snap_t;

   typedef struct {
      logic [1:0] id;
      logic [9:0] vec;
      logic       sc;
      logic       sz;
   } acc_t;

   snap_t snap_q[$];
   string snap_nm[$];
   acc_t  acc_q[$];
   int    errors = 0;
   int    checks = 0;

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_full(input string nm, input int inst, input logic rq, input logic [3:0] pd,
                           input logic e, input logic sv, input bit chk, input logic [1:0] id,
                           input logic [9:0] vec, input logic sc, input logic sz);
      snap_t s;
      s.cyc = cyc; s.inst = inst; s.rq = rq; s.pd = pd; s.e = e; s.sv = sv;
      s.chk_acc = chk; s.id = id; s.vec = vec; s.sc = sc; s.sz = sz;
      snap_q.push_back(s);
      snap_nm.push_back(nm);
   endtask

   task automatic exp_st(input string nm, input int inst, input logic rq, input logic [3:0] pd,
                         input logic e, input logic sv);
      exp_full(nm, inst, rq, pd, e, sv, 1'b0, 2'd0, 10'h0, 1'b0, 1'b0);
   endtask

   // Monitor: state snapshots due this cycle, plus every entry into service.
   logic prev_isv = 1'b0;
   initial forever begin
      @(negedge clk);
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
         snap_t s;
         string nm;
         s  = snap_q.pop_front();
         nm = snap_nm.pop_front();
         if (s.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: missed check at cycle %0d (now %0d)", nm, s.cyc, cyc);
         end else if (s.inst == 0) begin
            cmp({nm, ".int_req"}, int_req, s.rq);
            cmp({nm, ".pending"}, pending, s.pd);
            cmp({nm, ".ie"}, ie, s.e);
            cmp({nm, ".in_service"}, in_service, s.sv);
            if (s.chk_acc) begin
               cmp({nm, ".int_id"}, int_id, s.id);
               cmp({nm, ".int_vec"}, int_vec, s.vec);
               cmp({nm, ".shad_c"}, shad_c, s.sc);
               cmp({nm, ".shad_z"}, shad_z, s.sz);
            end
         end else begin
            cmp({nm, ".int_req"}, l_int_req, s.rq);
            cmp({nm, ".pending"}, l_pending, s.pd);
            cmp({nm, ".ie"}, l_ie, s.e);
            cmp({nm, ".in_service"}, l_in_service, s.sv);
            if (s.chk_acc) begin
               cmp({nm, ".int_id"}, l_int_id, s.id);
               cmp({nm, ".int_vec"}, l_int_vec, s.vec);
               cmp({nm, ".shad_c"}, l_shad_c, s.sc);
               cmp({nm, ".shad_z"}, l_shad_z, s.sz);
            end
         end
      end
      if (in_service && !prev_isv) begin
         if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept: unexpected accept id=%0d vec=%0h", int_id, int_vec);
         end else begin
            acc_t a;
            a = acc_q.pop_front();
            cmp("accept.int_id", int_id, a.id);
            cmp("accept.int_vec", int_vec, a.vec);
            cmp("accept.shad_c", shad_c, a.sc);
            cmp("accept.shad_z", shad_z, a.sz);
         end
      end
      prev_isv = in_service;
   end

   initial begin
      // reset values
      tick(); tick();
      exp_full("rst", 0, 0, 4'h0, 0, 0, 1, 2'd0, 10'h3F8, 0, 0);
      exp_full("rst_l", 1, 0, 4'h0, 0, 0, 1, 2'd0, 10'h3F8, 0, 0);
      tick(); rst = 1'b0;

      // single pulse on channel 2, accept with flags
      sei = 1; tick(); sei = 0;
      exp_st("sei", 0, 0, 4'h0, 1, 0);
      irq[2] = 1; tick(); irq[2] = 0; tick();
      exp_st("lat2", 0, 0, 4'h0, 1, 0);
      tick();
      exp_st("lat3", 0, 1, 4'b0100, 1, 0);
      int_ack = 1; c_flg = 1; z_flg = 0;
      acc_q.push_back('{2'd2, 10'h3FA, 1'b1, 1'b0});
      tick(); int_ack = 0;
      exp_full("acc1", 0, 0, 4'h0, 0, 1, 1, 2'd2, 10'h3FA, 1, 0);

      // simultaneous channels 3 and 1: priority then re-request after return
      retie = 1; tick(); retie = 0;
      exp_st("ret1", 0, 0, 4'h0, 1, 0);
      irq[3] = 1; irq[1] = 1; tick(); tick(); tick();
      exp_st("two", 0, 1, 4'b1010, 1, 0);
      int_ack = 1; c_flg = 0; z_flg = 1;
      acc_q.push_back('{2'd1, 10'h3F9, 1'b0, 1'b1});
      tick(); int_ack = 0;
      exp_full("acc_hi", 0, 0, 4'b1000, 0, 1, 1, 2'd1, 10'h3F9, 0, 1);
      retie = 1; tick(); retie = 0;
      exp_full("ret2", 0, 1, 4'b1000, 1, 0, 1, 2'd1, 10'h3F9, 0, 1);
      int_ack = 1; c_flg = 1; z_flg = 1;
      acc_q.push_back('{2'd3, 10'h3FB, 1'b1, 1'b1});
      tick(); int_ack = 0;
      exp_full("acc_lo", 0, 0, 4'h0, 0, 1, 1, 2'd3, 10'h3FB, 1, 1);
      retie = 1; tick(); retie = 0; irq[3] = 0; irq[1] = 0;
      exp_st("ret3", 0, 0, 4'h0, 1, 0);
      tick(); tick(); tick();
      exp_st("fall", 0, 0, 4'h0, 1, 0);

      // masked pending is kept and requests once unmasked
      mask_wr = 1; mask_din = 4'b1110; tick(); mask_wr = 0;
      irq[0] = 1; tick(); irq[0] = 0; tick(); tick();
      exp_st("masked", 0, 0, 4'b0001, 1, 0);
      mask_wr = 1; mask_din = 4'b1111; tick(); mask_wr = 0;
      exp_st("unmask", 0, 1, 4'b0001, 1, 0);
      int_ack = 1; c_flg = 0; z_flg = 0;
      acc_q.push_back('{2'd0, 10'h3F8, 1'b0, 1'b0});
      tick(); int_ack = 0;
      exp_st("acc0", 0, 0, 4'h0, 0, 1);
      retie = 1; tick(); retie = 0;
      exp_st("ret4", 0, 0, 4'h0, 1, 0);

      // new edge in the accept cycle keeps the pending bit
      irq[0] = 1; tick(); irq[0] = 0; tick(); tick();
      exp_st("p0", 0, 1, 4'b0001, 1, 0);
      irq[0] = 1; tick(); tick();
      int_ack = 1; c_flg = 1; z_flg = 0;
      acc_q.push_back('{2'd0, 10'h3F8, 1'b1, 1'b0});
      tick(); int_ack = 0; irq[0] = 0;
      exp_st("setwin", 0, 0, 4'b0001, 0, 1);
      retie = 1; tick(); retie = 0;
      exp_st("ret_p", 0, 1, 4'b0001, 1, 0);
      int_ack = 1; c_flg = 0; z_flg = 0;
      acc_q.push_back('{2'd0, 10'h3F8, 1'b0, 1'b0});
      tick(); int_ack = 0;
      exp_st("acc0b", 0, 0, 4'h0, 0, 1);
      retie = 1; tick(); retie = 0;
      exp_st("ret5", 0, 0, 4'h0, 1, 0);

      // SEI+CLI, then ACK+RETIE together with a request
      sei = 1; cli = 1; tick(); sei = 0; cli = 0;
      exp_st("seicli", 0, 0, 4'h0, 0, 0);
      sei = 1; tick(); sei = 0;
      irq[2] = 1; tick(); irq[2] = 0; tick(); tick();
      exp_st("p2", 0, 1, 4'b0100, 1, 0);
      retie = 1; int_ack = 1; c_flg = 0; z_flg = 1;
      acc_q.push_back('{2'd2, 10'h3FA, 1'b0, 1'b1});
      tick(); retie = 0; int_ack = 0;
      exp_st("ackret", 0, 0, 4'h0, 0, 1);

      // SEI/CLI during service leave the state alone
      sei = 1; tick(); sei = 0;
      exp_st("sei_sv", 0, 0, 4'h0, 1, 1);
      cli = 1; tick(); cli = 0;
      exp_st("cli_sv", 0, 0, 4'h0, 0, 1);

      // asynchronous reset mid-service with pending requests
      irq[3] = 1; irq[1] = 1; tick(); tick(); tick();
      exp_st("pend_sv", 0, 0, 4'b1010, 0, 1);
      tick(); rst = 1'b1;
      exp_full("async_rst", 0, 0, 4'h0, 0, 0, 1, 2'd0, 10'h3F8, 0, 0);

      // inputs held high through reset release look like fresh edges
      tick(); rst = 1'b0;
      tick(); tick();
      exp_st("rel2", 0, 0, 4'h0, 0, 0);
      tick();
      exp_st("rel3", 0, 0, 4'b1010, 0, 0);
      irq = '0;

      // level channel 0 on the second instance
      l_sei = 1; tick(); l_sei = 0;
      l_irq[0] = 1; tick(); tick();
      exp_st("lv2", 1, 0, 4'h0, 1, 0);
      tick();
      exp_st("lv3", 1, 1, 4'b0001, 1, 0);
      l_ack = 1; tick(); l_ack = 0;
      exp_full("lv_acc", 1, 0, 4'b0001, 0, 1, 1, 2'd0, 10'h3F8, 0, 0);
      l_retie = 1; tick(); l_retie = 0;
      exp_st("lv_ret", 1, 1, 4'b0001, 1, 0);
      l_irq[0] = 0; tick(); tick();
      exp_st("lv_f2", 1, 1, 4'b0001, 1, 0);
      tick();
      exp_st("lv_f3", 1, 0, 4'h0, 1, 0);

      tick(); tick();
      cmp("snap_q_drained", snap_q.size(), 0);
      cmp("acc_q_drained", acc_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
